// File: rtl/code_loader_pkg.sv
// rtl/code_loader_pkg.sv - shared constants and state encoding for the code loader
package code_loader_pkg;

    localparam int CODE_WORDS = 8;
    localparam int ADDR_W     = $clog2(CODE_WORDS);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDX,
        S_CNT,
        S_DATA,
        S_CSUM
    } state_t;

endpackage

// File: rtl/code_loader_if.sv
// rtl/code_loader_if.sv - byte stream in, code memory write port out
interface code_loader_if
    import code_loader_pkg::*;
#(
    parameter int AW = ADDR_W
) ();

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          cm_we;
    logic [AW-1:0] cm_addr;
    logic [31:0]   cm_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, cm_we, cm_addr, cm_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, cm_we, cm_addr, cm_wdata
    );

endinterface

// File: rtl/code_loader_word_assembler.sv
// rtl/code_loader_word_assembler.sv - packs bytes little-endian into 32-bit words
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        load,
    input  logic        clear,
    output logic [31:0] word,
    output logic [1:0]  byte_idx,
    output logic        complete
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        complete_q;

    // complete is a registered one-cycle pulse, so it can serve directly as the write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q     <= '0;
            idx_q      <= '0;
            complete_q <= 1'b0;
        end else begin
            complete_q <= load && (idx_q == 2'd3);
            if (clear) begin
                idx_q <= '0;
            end else if (load) begin
                word_q[8*idx_q +: 8] <= byte_in;
                idx_q                <= idx_q + 2'd1;
            end
        end
    end

    assign word     = word_q;
    assign byte_idx = idx_q;
    assign complete = complete_q;

endmodule

// File: rtl/code_loader.sv
// rtl/code_loader.sv - framed byte-stream loader for the cpu code memory
module code_loader
    import code_loader_pkg::*;
#(
    parameter int CODE_WORDS_P = CODE_WORDS,
    parameter int ADDR_W_P     = $clog2(CODE_WORDS_P)
) (
    input  logic           clk,
    input  logic           reset,
    code_loader_if.slave   bus,
    output logic           cpu_nreset,
    output logic           done,
    output logic           err
);

    state_t              state;
    logic                rx_ready_q;
    logic [ADDR_W_P-1:0] addr;
    logic [7:0]          cnt;
    logic [7:0]          csum;

    logic                accept;
    logic                asm_load;
    logic                asm_clear;
    logic [31:0]         asm_word;
    logic [1:0]          asm_idx;
    logic                asm_complete;
    logic                last_byte;
    logic [ADDR_W_P-1:0] addr_next;

    assign accept    = bus.rx_valid && rx_ready_q;
    assign asm_load  = accept && (state == S_DATA);
    assign asm_clear = accept && (state == S_CNT);
    assign last_byte = asm_idx == 2'd3;
    assign addr_next = (addr == ADDR_W_P'(CODE_WORDS_P - 1)) ? '0 : addr + 1'b1;

    word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .byte_in  (bus.rx_data),
        .load     (asm_load),
        .clear    (asm_clear),
        .word     (asm_word),
        .byte_idx (asm_idx),
        .complete (asm_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rx_ready_q <= 1'b0;
            addr       <= '0;
            cnt        <= '0;
            csum       <= '0;
            cpu_nreset <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done       <= 1'b0;
            rx_ready_q <= 1'b1;
            // address advances only once the strobe cycle carrying it has passed
            if (asm_complete) begin
                addr <= addr_next;
            end
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            csum       <= '0;
                            err        <= 1'b0;
                            cpu_nreset <= 1'b0;
                            state      <= S_IDX;
                        end
                    end
                    S_IDX: begin
                        addr  <= bus.rx_data[ADDR_W_P-1:0];
                        csum  <= csum ^ bus.rx_data;
                        state <= S_CNT;
                    end
                    S_CNT: begin
                        cnt   <= bus.rx_data;
                        csum  <= csum ^ bus.rx_data;
                        state <= (bus.rx_data == 8'd0) ? S_CSUM : S_DATA;
                    end
                    S_DATA: begin
                        csum <= csum ^ bus.rx_data;
                        if (last_byte) begin
                            rx_ready_q <= 1'b0;
                            cnt        <= cnt - 8'd1;
                            if (cnt == 8'd1) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_data == csum) begin
                            cpu_nreset <= 1'b1;
                            done       <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.cm_we    = asm_complete;
    assign bus.cm_addr  = addr;
    assign bus.cm_wdata = asm_word;

endmodule

// File: tb/tb_code_loader.sv
// tb/tb_code_loader.sv - scoreboard bench for code_loader with randomized frames
module tb_code_loader;
    import code_loader_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_nreset;
    logic done;
    logic err;

    code_loader_if bus ();

    code_loader dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_nreset (cpu_nreset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_done;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] frame_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         exp_nreset = 1'b0;
    bit         exp_err = 1'b0;
    bit         stall_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and every done pulse must match the head of the queue
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.cm_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_write", 32'(e.is_done), 32'd0);
                    chk("cm_addr", 32'(bus.cm_addr), 32'(e.addr));
                    chk("cm_wdata", bus.cm_wdata, e.data);
                end
            end
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_done", 32'(e.is_done), 32'd1);
                end
            end
        end
    end

    // Reference model: decode the frame bytes directly into expected writes and outcome
    task automatic model_frame();
        logic [7:0] x;
        int         n;
        int         a;
        ev_t        e;
        x = 8'h00;
        for (int i = 1; i < frame_q.size() - 1; i++) x ^= frame_q[i];
        n = int'(frame_q[2]);
        for (int w = 0; w < n; w++) begin
            a = (int'(frame_q[1]) + w) % CODE_WORDS;
            e.is_done = 1'b0;
            e.addr    = a[ADDR_W-1:0];
            e.data    = {frame_q[3+4*w+3], frame_q[3+4*w+2], frame_q[3+4*w+1], frame_q[3+4*w]};
            exp_q.push_back(e);
        end
        if (x == frame_q[frame_q.size()-1]) begin
            e.is_done = 1'b1;
            e.addr    = '0;
            e.data    = '0;
            exp_q.push_back(e);
            exp_nreset = 1'b1;
            exp_err    = 1'b0;
        end else begin
            exp_nreset = 1'b0;
            exp_err    = 1'b1;
        end
    endtask

    task automatic build_frame(input logic [7:0] idx, input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        frame_q = {};
        frame_q.push_back(SYNC_BYTE);
        frame_q.push_back(idx);
        frame_q.push_back(8'(n));
        x = idx ^ 8'(n);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            x ^= b;
        end
        frame_q.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    // Called and returns at a negedge; the byte is taken on the posedge in between
    task automatic send_byte(input logic [7:0] b);
        int wait_cycles;
        if (stall_en && $urandom_range(0, 2) == 0) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        wait_cycles  = 0;
        while (!bus.rx_ready && wait_cycles < 50) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (!bus.rx_ready) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_cpu_nreset"}, 32'(cpu_nreset), 32'(exp_nreset));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic send_frame(input string name);
        model_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        drain(name);
    endtask

    initial begin
        ev_t e;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset held three cycles: everything sits at its reset value
        repeat (3) begin
            @(negedge clk);
            chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
            chk("rst_cm_we", 32'(bus.cm_we), 32'd0);
            chk("rst_cm_addr", 32'(bus.cm_addr), 32'd0);
            chk("rst_cm_wdata", bus.cm_wdata, 32'd0);
            chk("rst_cpu_nreset", 32'(cpu_nreset), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("rel_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rel_cpu_nreset", 32'(cpu_nreset), 32'd0);

        // Reference program: ADD / branch loop
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h20, 8'h82, 8'hE0,
                    8'hFD, 8'hFF, 8'hFF, 8'hEA, 8'h56};
        send_frame("prog_good");

        // Same program, corrupted checksum
        frame_q[11] = 8'h57;
        send_frame("prog_bad");

        // Following good frame clears err as soon as its sync lands
        frame_q[11] = 8'h56;
        model_frame();
        send_byte(frame_q[0]);
        chk("sync_clears_err", 32'(err), 32'd0);
        chk("sync_holds_cpu", 32'(cpu_nreset), 32'd0);
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i]);
        drain("prog_recover");

        // Junk before sync, then a frame wrapping from address 7 to 0
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        build_frame(8'h07, 2, 1'b0);
        send_frame("wrap");

        // Zero-length frame
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'h03};
        send_frame("count0");

        // Random frames under random rx_valid stalls, counts beyond depth included
        stall_en = 1'b1;
        for (int f = 0; f < 12; f++) begin
            build_frame(8'($urandom_range(0, 255)), int'($urandom_range(0, 11)),
                        ($urandom_range(0, 3) == 0));
            send_frame("rand");
        end

        // Reset after five data bytes: one word written, nothing afterwards
        build_frame(8'h05, 2, 1'b0);
        e.is_done = 1'b0;
        e.addr    = 3'd5;
        e.data    = {frame_q[6], frame_q[5], frame_q[4], frame_q[3]};
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i]);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_nreset = 1'b0;
        exp_err    = 1'b0;
        repeat (20) @(negedge clk);
        drain("abort");
        chk("abort_cm_addr", 32'(bus.cm_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
